siso_alpha_lifo: RTL and testbench
==================================

// Module: siso_alpha_lifo
// PURPOSE
//  Parametrised forward-recursion unit for the 8-state LTE RSC max-log-MAP SISO decoder.
//  Per trellis step: accepts sys/parity/apriori LLRs, forms branch metrics, updates and normalises the 8 alphas, stores alpha_k in RAM.
//  After the block, replays stored alphas in reverse order (k=K-1..0) with valid/ready flow control, so the backward beta/LLR stage runs without re-computation.
//  Sits between the sys/parity splitter and the beta/extrinsic stage.
// PARAMETERS
//  W_LLR    16    signed width of sys, par, apr inputs
//  W_M      18    signed width of each state metric (W_M >= W_LLR+2)
//  MAX_BLK  6144  max block length K (RAM depth)
//  W_K      13    width of blklen / step counters (2**W_K > MAX_BLK)
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         synchronous active-high reset
//  blklen        in   W_K       block length K for next block
//  blklen_valid  in   1         blklen qualifier; sampled only in IDLE
//  blk_err       out  1         1-cycle pulse: blklen rejected (0 or >MAX_BLK)
//  sys           in   W_LLR     systematic LLR, step k
//  par           in   W_LLR     parity LLR, step k
//  apr           in   W_LLR     a-priori LLR, step k
//  in_valid      in   1         sys/par/apr valid
//  in_ready      out  1         1 only in FWD; transfer = in_valid & in_ready
//  alpha_out     out  8*W_M     {alpha[7],...,alpha[0]} of replayed step
//  out_valid     out  1         alpha_out valid
//  out_ready     in   1         downstream accept; transfer = out_valid & out_ready
//  out_last      out  1         marks alpha_0 (final replayed word)
//  busy          out  1         state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, out_valid, out_last, blk_err, busy = 0; alpha_out = 0; alpha regs = init vector; counters = 0.
//  FSM: IDLE -> FWD on blklen_valid with 1<=blklen<=MAX_BLK (latch K, k=0, alpha=init); else stay IDLE, pulse blk_err next cycle.
//   FWD: each transfer writes current alpha (alpha_k) to RAM[k], then updates alpha, k++. After transfer with k==K-1 -> REV.
//   REV: reads RAM[K-1] down to RAM[0]; after transfer of the out_last word -> IDLE.
//  blklen_valid outside IDLE is ignored. in_valid outside FWD is ignored (in_ready=0). No wrap: counters never exceed K-1.
//  Init vector: alpha[0]=0, alpha[1..7]=NEG = -(2**(W_M-2)).
//  Trellis: state s={s1,s2,s3} (s1 MSB); a=u^s2^s3; c=a^s1^s3; next state {a,s1,s2}.
//  Branch metric: L1=sext(sys)+sext(apr); gamma(u,c)=(u?L1:0)+(c?par:0), W_M-bit signed.
//  Update: alpha'[ns]=max over the 2 (s,u) with next(s,u)=ns of alpha[s]+gamma(u,c(s,u)).
//  Normalise: alpha'' = alpha' - alpha'[0] for all 8; saturate each to W_M signed range. alpha''[0] always 0.
//  Alpha update completes in the same cycle as the transfer (registered, 1-cycle recursion).
//  Replay: RAM read issued the cycle REV is entered; out_valid rises 2 clocks after the last input transfer edge.
//   Output is a held register: alpha_out/out_last stable while out_valid & !out_ready; next read issued only on transfer.
//   Sustained out_ready=1 gives 1 word/cycle; out_last=1 only with alpha_0 word.
//  K=1: FWD takes one transfer; REV emits one word (init vector) with out_last=1.
//  rst mid-block: immediate return to IDLE next cycle, outputs to reset values, partial block discarded.
// TESTING
//  1. rst, blklen=4 valid, all LLRs 0 -> 4 words: alpha_3, alpha_2, alpha_1, alpha_0; alpha_1=[0,N,N,N,0,N,N,N] (N=-65536), alpha_0=init, out_last on 4th.
//  2. K=2, step0 sys=100, par=0, apr=0 -> word1 alpha_1: [0]=0,[4]=100, others N; word2 = init with out_last.
//  3. blklen=0 and blklen=MAX_BLK+1 -> blk_err pulse, state stays IDLE, in_ready=0.
//  4. K=8 random LLRs, out_ready toggled random 50% -> alpha_out stable during stalls, order/values match golden model.
//  5. Large LLRs (sys=apr=+32767) over K=MAX_BLK -> metrics saturate, never wrap; alpha[0]=0 every word.
//  6. rst asserted mid-FWD and mid-REV -> IDLE next cycle, out_valid=0; following K=3 block correct.

Source files
------------

// File: rtl/siso_alpha_lifo.sv
// siso_alpha_lifo
//   Forward (alpha) recursion for the 8-state LTE RSC max-log-MAP SISO decoder.
//   Each accepted input step stores the current alpha vector in RAM, then advances the
//   recursion. When the block is done, the stored vectors are replayed last-to-first.
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   blklen/blklen_valid block length K for the next block, sampled only when idle
//   blk_err             1-cycle pulse when blklen is 0 or above MAX_BLK
//   sys/par/apr         signed LLRs for step k, qualified by in_valid/in_ready
//   alpha_out           {alpha[7],...,alpha[0]} of the replayed step
//   out_valid/out_ready replay handshake; out_last flags the alpha_0 word
//   busy                high whenever a block is in progress
module siso_alpha_lifo #(
    parameter int unsigned W_LLR   = 16,
    parameter int unsigned W_M     = 18,
    parameter int unsigned MAX_BLK = 6144,
    parameter int unsigned W_K     = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W_K-1:0]          blklen,
    input  logic                    blklen_valid,
    output logic                    blk_err,
    input  logic signed [W_LLR-1:0] sys,
    input  logic signed [W_LLR-1:0] par,
    input  logic signed [W_LLR-1:0] apr,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [8*W_M-1:0]        alpha_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy
);

    localparam int unsigned WX = W_M + 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_REV  = 2'd2;

    localparam logic signed [W_M-1:0] NEG    = {2'b11, {(W_M-2){1'b0}}};
    localparam logic signed [WX-1:0]  SAT_HI = {3'b000, {(W_M-1){1'b1}}};
    localparam logic signed [WX-1:0]  SAT_LO = {3'b111, {(W_M-1){1'b0}}};

    logic [1:0]              state_q;
    logic [W_K-1:0]          blk_q;
    logic [W_K-1:0]          k_q;
    logic signed [W_M-1:0]   alpha_q [8];
    logic                    rd_more_q;
    logic                    p_valid_q;
    logic                    p_last_q;
    logic [8*W_M-1:0]        p_data_q;
    logic [8*W_M-1:0]        mem [MAX_BLK];

    logic                    in_fire;
    logic                    out_fire;
    logic                    load_out;
    logic                    issue;

    logic signed [WX-1:0]    l1;
    logic signed [WX-1:0]    gam [4];
    logic signed [WX-1:0]    cand0 [8];
    logic signed [WX-1:0]    cand1 [8];
    logic signed [WX-1:0]    best [8];
    logic signed [WX-1:0]    diff [8];
    logic signed [W_M-1:0]   alpha_nxt [8];
    logic [8*W_M-1:0]        alpha_pk;

    assign in_ready = (state_q == ST_FWD);
    assign busy     = (state_q != ST_IDLE);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Two-stage replay pipe: RAM data register, then the held output register.
    assign load_out = p_valid_q & (~out_valid | out_ready);
    assign issue    = (state_q == ST_REV) & rd_more_q & (~p_valid_q | load_out);

    // Predecessors of ns={a,s1,s2} are s={s1,s2,b}; u and c follow from a and b.
    always_comb begin
        l1     = WX'(sys) + WX'(apr);
        gam[0] = '0;
        gam[1] = WX'(par);
        gam[2] = l1;
        gam[3] = l1 + WX'(par);
        for (int ns = 0; ns < 8; ns++) begin
            cand0[ns] = WX'(alpha_q[{ns[1], ns[0], 1'b0}])
                      + gam[{ns[2] ^ ns[0], ns[2] ^ ns[1]}];
            cand1[ns] = WX'(alpha_q[{ns[1], ns[0], 1'b1}])
                      + gam[{~(ns[2] ^ ns[0]), ~(ns[2] ^ ns[1])}];
            best[ns]  = (cand1[ns] > cand0[ns]) ? cand1[ns] : cand0[ns];
        end
        for (int ns = 0; ns < 8; ns++) begin
            diff[ns] = best[ns] - best[0];
            if (diff[ns] > SAT_HI) begin
                alpha_nxt[ns] = W_M'(SAT_HI);
            end else if (diff[ns] < SAT_LO) begin
                alpha_nxt[ns] = W_M'(SAT_LO);
            end else begin
                alpha_nxt[ns] = W_M'(diff[ns]);
            end
        end
    end

    always_comb begin
        alpha_pk = '0;
        for (int i = 0; i < 8; i++) begin
            alpha_pk[i*W_M +: W_M] = alpha_q[i];
        end
    end

    // Alpha store; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (in_fire && !rst) begin
            mem[k_q] <= alpha_pk;
        end
        if (issue) begin
            p_data_q <= mem[k_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            blk_q     <= '0;
            k_q       <= '0;
            for (int i = 0; i < 8; i++) begin
                alpha_q[i] <= (i == 0) ? '0 : NEG;
            end
            rd_more_q <= 1'b0;
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
            alpha_out <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            blk_err   <= 1'b0;
        end else begin
            blk_err <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (blklen_valid) begin
                        if (blklen != '0 && blklen <= W_K'(MAX_BLK)) begin
                            state_q <= ST_FWD;
                            blk_q   <= blklen;
                            k_q     <= '0;
                            for (int i = 0; i < 8; i++) begin
                                alpha_q[i] <= (i == 0) ? '0 : NEG;
                            end
                        end else begin
                            blk_err <= 1'b1;
                        end
                    end
                end
                ST_FWD: begin
                    if (in_fire) begin
                        alpha_q <= alpha_nxt;
                        // k stays at K-1 so the replay starts from the last stored step.
                        if (k_q == blk_q - W_K'(1)) begin
                            state_q   <= ST_REV;
                            rd_more_q <= 1'b1;
                        end else begin
                            k_q <= k_q + W_K'(1);
                        end
                    end
                end
                ST_REV: begin
                    if (issue) begin
                        p_valid_q <= 1'b1;
                        p_last_q  <= (k_q == '0);
                        if (k_q == '0) begin
                            rd_more_q <= 1'b0;
                        end else begin
                            k_q <= k_q - W_K'(1);
                        end
                    end else if (load_out) begin
                        p_valid_q <= 1'b0;
                    end
                    if (load_out) begin
                        alpha_out <= p_data_q;
                        out_valid <= 1'b1;
                        out_last  <= p_last_q;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            state_q <= ST_IDLE;
                            k_q     <= '0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_siso_alpha_lifo.sv
module tb_siso_alpha_lifo;

    localparam int W_LLR   = 16;
    localparam int W_M     = 18;
    localparam int MAX_BLK = 6144;
    localparam int W_K     = 13;
    localparam int WA      = 8 * W_M;
    localparam int NEG_I   = -(2 ** (W_M - 2));
    localparam int SAT_HI  = 2 ** (W_M - 1) - 1;
    localparam int SAT_LO  = -(2 ** (W_M - 1));

    logic                    clk = 1'b0;
    logic                    rst;
    logic [W_K-1:0]          blklen;
    logic                    blklen_valid;
    logic                    blk_err;
    logic signed [W_LLR-1:0] sys, par, apr;
    logic                    in_valid;
    logic                    in_ready;
    logic [WA-1:0]           alpha_out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic                    busy;

    int total = 0;
    int bad   = 0;
    int sys_a [MAX_BLK];
    int par_a [MAX_BLK];
    int apr_a [MAX_BLK];
    logic [WA-1:0] exp_w [MAX_BLK];
    int n_in, n_out;

    siso_alpha_lifo #(
        .W_LLR(W_LLR), .W_M(W_M), .MAX_BLK(MAX_BLK), .W_K(W_K)
    ) dut (
        .clk(clk), .rst(rst), .blklen(blklen), .blklen_valid(blklen_valid),
        .blk_err(blk_err), .sys(sys), .par(par), .apr(apr), .in_valid(in_valid),
        .in_ready(in_ready), .alpha_out(alpha_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_w(input string tag, input logic [WA-1:0] obs, input logic [WA-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word with zero in every state flagged by zm and NEG elsewhere.
    function automatic logic [WA-1:0] mask_vec(input logic [7:0] zm);
        logic [WA-1:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[i*W_M +: W_M] = zm[i] ? '0 : W_M'(NEG_I);
        return w;
    endfunction

    // Reference: walk every (state, bit) branch forward and keep the best per target state.
    task automatic model(input int k);
        int a [8];
        int na [8];
        bit seen [8];
        int s1, s2, s3, aa, c, ns, m, base, v;
        logic [WA-1:0] w;
        for (int i = 0; i < 8; i++) a[i] = (i == 0) ? 0 : NEG_I;
        for (int st = 0; st < k; st++) begin
            w = '0;
            for (int i = 0; i < 8; i++) w[i*W_M +: W_M] = W_M'(a[i]);
            exp_w[st] = w;
            for (int i = 0; i < 8; i++) begin seen[i] = 0; na[i] = 0; end
            for (int s = 0; s < 8; s++) begin
                for (int u = 0; u < 2; u++) begin
                    s1 = (s >> 2) & 1;
                    s2 = (s >> 1) & 1;
                    s3 = s & 1;
                    aa = u ^ s2 ^ s3;
                    c  = aa ^ s1 ^ s3;
                    ns = aa * 4 + s1 * 2 + s2;
                    m  = a[s] + (u != 0 ? sys_a[st] + apr_a[st] : 0) + (c != 0 ? par_a[st] : 0);
                    if (!seen[ns] || m > na[ns]) na[ns] = m;
                    seen[ns] = 1;
                end
            end
            base = na[0];
            for (int i = 0; i < 8; i++) begin
                v = na[i] - base;
                if (v > SAT_HI) v = SAT_HI;
                if (v < SAT_LO) v = SAT_LO;
                a[i] = v;
            end
        end
    endtask

    task automatic start_blk(input int k);
        blklen       = W_K'(k);
        blklen_valid = 1'b1;
        tick();
        blklen_valid = 1'b0;
        check_i("start_busy", int'(busy), 1);
        check_i("start_in_ready", int'(in_ready), 1);
    endtask

    task automatic feed(input int k, input int upto, input bit rnd);
        int guard;
        bit xfer;
        guard = 0;
        n_in  = 0;
        while (n_in < upto && guard < 20 * k + 100) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            sys = W_LLR'(sys_a[n_in]);
            par = W_LLR'(par_a[n_in]);
            apr = W_LLR'(apr_a[n_in]);
            xfer = in_valid & in_ready;
            tick();
            if (xfer) n_in++;
            guard++;
        end
        in_valid = 1'b0;
        check_i("feed_count", n_in, upto);
    endtask

    task automatic lat_check();
        check_i("lat_edge0", int'(out_valid), 0);
        tick();
        check_i("lat_edge1", int'(out_valid), 0);
        tick();
        check_i("lat_edge2", int'(out_valid), 1);
    endtask

    task automatic drain(input int k, input int upto, input bit rnd);
        int guard;
        guard = 0;
        n_out = 0;
        while (n_out < upto && guard < 20 * k + 100) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                check_w("alpha_out", alpha_out, exp_w[k-1-n_out]);
                if (out_ready) begin
                    check_i("out_last", int'(out_last), int'(n_out == k - 1));
                    n_out++;
                end
            end
            tick();
            guard++;
        end
        out_ready = 1'b0;
        check_i("drain_count", n_out, upto);
    endtask

    task automatic run_block(input int k, input bit rnd_in, input bit rnd_out, input bit use_model);
        if (use_model) model(k);
        start_blk(k);
        feed(k, k, rnd_in);
        lat_check();
        drain(k, k, rnd_out);
        check_i("end_busy", int'(busy), 0);
        check_i("end_out_valid", int'(out_valid), 0);
    endtask

    task automatic rand_llrs(input int k);
        for (int i = 0; i < k; i++) begin
            sys_a[i] = int'($urandom_range(0, 65535)) - 32768;
            par_a[i] = int'($urandom_range(0, 65535)) - 32768;
            apr_a[i] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    task automatic zero_llrs(input int k);
        for (int i = 0; i < k; i++) begin
            sys_a[i] = 0;
            par_a[i] = 0;
            apr_a[i] = 0;
        end
    endtask

    initial begin
        rst = 1'b1;
        blklen = '0;
        blklen_valid = 1'b0;
        sys = '0;
        par = '0;
        apr = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check_i("rst_busy", int'(busy), 0);
        check_i("rst_in_ready", int'(in_ready), 0);
        check_i("rst_out_valid", int'(out_valid), 0);
        check_i("rst_out_last", int'(out_last), 0);
        check_i("rst_blk_err", int'(blk_err), 0);
        check_w("rst_alpha_out", alpha_out, '0);
        rst = 1'b0;
        tick();

        // All-zero LLRs: hand-derived alpha vectors.
        zero_llrs(4);
        exp_w[0] = mask_vec(8'h01);
        exp_w[1] = mask_vec(8'h11);
        exp_w[2] = mask_vec(8'h55);
        exp_w[3] = mask_vec(8'hFF);
        run_block(4, 1'b0, 1'b0, 1'b0);

        // K=2 with a single positive systematic value.
        zero_llrs(2);
        sys_a[0] = 100;
        run_block(2, 1'b0, 1'b0, 1'b1);

        // Rejected block lengths.
        blklen = '0;
        blklen_valid = 1'b1;
        in_valid = 1'b1;
        tick();
        blklen_valid = 1'b0;
        check_i("err0_pulse", int'(blk_err), 1);
        check_i("err0_busy", int'(busy), 0);
        check_i("err0_in_ready", int'(in_ready), 0);
        tick();
        check_i("err0_clear", int'(blk_err), 0);
        blklen = W_K'(MAX_BLK + 1);
        blklen_valid = 1'b1;
        tick();
        blklen_valid = 1'b0;
        in_valid = 1'b0;
        check_i("errmax_pulse", int'(blk_err), 1);
        check_i("errmax_busy", int'(busy), 0);
        check_i("errmax_in_ready", int'(in_ready), 0);
        tick();
        check_i("errmax_clear", int'(blk_err), 0);

        // Random LLRs with random input and output stalls.
        for (int r = 0; r < 3; r++) begin
            rand_llrs(8);
            run_block(8, 1'b1, 1'b1, 1'b1);
        end

        // Single-step block.
        rand_llrs(1);
        run_block(1, 1'b0, 1'b1, 1'b1);

        // Full-length block with large LLRs.
        for (int i = 0; i < MAX_BLK; i++) begin
            sys_a[i] = 32767;
            apr_a[i] = 32767;
            par_a[i] = int'($urandom_range(0, 65535)) - 32768;
        end
        run_block(MAX_BLK, 1'b0, 1'b0, 1'b1);

        // Reset during the forward pass.
        rand_llrs(8);
        model(8);
        start_blk(8);
        feed(8, 3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_i("rstfwd_busy", int'(busy), 0);
        check_i("rstfwd_in_ready", int'(in_ready), 0);
        check_i("rstfwd_out_valid", int'(out_valid), 0);

        // Reset during replay.
        rand_llrs(5);
        model(5);
        start_blk(5);
        feed(5, 5, 1'b0);
        lat_check();
        drain(5, 2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_i("rstrev_busy", int'(busy), 0);
        check_i("rstrev_out_valid", int'(out_valid), 0);
        check_i("rstrev_out_last", int'(out_last), 0);
        check_w("rstrev_alpha_out", alpha_out, '0);

        rand_llrs(3);
        run_block(3, 1'b1, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
